bitsync_ctrl_div: RTL and testbench
===================================

// Module: bitsync_ctrl_div
// PURPOSE
//  Control/divide stage of the QPSK bit-synchroniser DPLL; sits directly downstream of differpd.
//  Takes differpd's one-cycle lead/lag pulses, smooths them with a random-walk filter, and
//  stretches/shortens the local symbol period by one clk32 cycle.
//  Generates the 1:1-duty in-phase/quadrature sync clocks fed back to differpd, a symbol strobe
//  for the sampler, and a lock flag.
// PARAMETERS
//  DIV_N   32  clk32 cycles per nominal symbol; multiple of 4, >= 8
//  FILT_N  4   random-walk threshold (|acc| reaching FILT_N fires a correction); >= 1, 1 = unfiltered
//  LOCK_N  16  consecutive uncorrected symbols required to assert locked; >= 1
// PORTS
//  clk32    in   1  system clock, 32 MHz
//  rst      in   1  reset; asynchronous, active-high
//  pd_bef   in   1  one-cycle pulse: local clock early (edge seen while clk_i high)
//  pd_aft   in   1  one-cycle pulse: local clock late (edge seen while clk_q high)
//  clk_i    out  1  in-phase sync clock, 1:1 duty, period DIV_N nominal
//  clk_q    out  1  quadrature sync clock, lags clk_i by DIV_N/4 cycles
//  sym_stb  out  1  one-cycle strobe coincident with clk_i rising
//  locked   out  1  high after LOCK_N consecutive symbols with no correction
// BEHAVIOUR
//  Reset (async): cnt=0, acc=0, pending=NONE, lock_cnt=0. clk_i, clk_q, sym_stb and locked all 0.
//  Filter: acc is signed, range (-FILT_N, +FILT_N).
//   - pd_bef alone: acc+1. pd_aft alone: acc-1. Both or neither: acc held.
//   - acc reaching +FILT_N requests RET (retard) and clears acc to 0 in the same cycle.
//   - acc reaching -FILT_N requests ADV (advance) and clears acc to 0 in the same cycle.
//  Pending correction (one slot: NONE/ADV/RET):
//   - A request arriving while the slot is NONE is latched.
//   - Same kind while pending: discarded.
//   - Opposite kind while pending: clears the slot to NONE (net zero).
//  Phase counter cnt advances every clk32 cycle. Wrap point per period:
//   - NONE: wraps at DIV_N-1 (period DIV_N).
//   - RET: wraps at DIV_N (period DIV_N+1).
//   - ADV: wraps at DIV_N-2 (period DIV_N-1).
//   - The slot is sampled and cleared only on the wrap cycle, so at most one correction per symbol.
//   - A request arriving on the wrap cycle itself applies to the following period.
//  Decode (registered, one clk32 cycle after cnt):
//   - clk_i = (cnt < DIV_N/2).
//   - clk_q = (DIV_N/4 <= cnt < 3*DIV_N/4).
//   - sym_stb = (cnt == 0).
//   - Extra count DIV_N (RET) decodes clk_i=0, clk_q=0, so the low phase of both clocks is stretched.
//   - ADV removes count DIV_N-1, shortening the low phase of both clocks.
//  Lock:
//   - lock_cnt increments on each wrap with NONE applied, saturating at LOCK_N.
//   - A wrap applying ADV or RET clears lock_cnt to 0.
//   - locked = (lock_cnt == LOCK_N), registered.
//  Reset mid-operation: everything returns to reset state at once. Any pending correction and
//   partial acc are lost. After release, clk_i=1 and sym_stb=1 on the first clk32 edge.
// STRUCTURE
//  Package qpsk_sync_pkg:
//   - corr_t enum {CORR_NONE, CORR_ADV, CORR_RET}.
//   - clog2-based width constants for cnt (holds DIV_N), acc (signed, holds +/-FILT_N) and lock_cnt.
//  Sub-module rw_filter:
//   - Inputs pd_bef/pd_aft; outputs one-cycle req_adv/req_ret.
//   - Owns acc.
//  Top level holds the pending slot, phase counter, decode registers and lock counter.
// TESTING (DIV_N=32, FILT_N=4, LOCK_N=16)
//  1. Free run, no pd pulses -> clk_i period 32, high 16; clk_q rises 8 cycles after clk_i;
//     sym_stb every 32; locked rises after 16 symbols.
//  2. 3 pd_bef pulses -> periods stay 32. 4th pulse -> next period 33, locked drops,
//     then periods return to 32.
//  3. 4 pd_aft pulses -> exactly one period of 31; a further 4 in the same period change nothing
//     beyond that single 31-cycle period.
//  4. 10 cycles with pd_bef=pd_aft=1 -> acc stays 0; no correction; locked unaffected.
//  5. 4 pd_bef (RET pending) then 4 pd_aft before the wrap -> slot cleared; period 32; lock_cnt
//     keeps counting.
//  6. Drive acc to +3, assert rst mid-period -> all outputs 0 during reset. After release,
//     clk_i high on first edge and 4 further pd_bef pulses are needed for a 33-cycle period.

Source files
------------

// File: rtl/qpsk_sync_pkg.sv
// Shared types, width helpers and the pending-correction merge rule for the
// QPSK bit-synchroniser control/divide stage.
package qpsk_sync_pkg;

    typedef enum logic [1:0] {
        CORR_NONE = 2'd0,
        CORR_ADV  = 2'd1,
        CORR_RET  = 2'd2
    } corr_t;

    localparam int DIV_N_DEF  = 32;
    localparam int FILT_N_DEF = 4;
    localparam int LOCK_N_DEF = 16;

    // Counter must hold DIV_N itself (the stretched RET period).
    function automatic int cnt_width(input int div_n);
        return $clog2(div_n + 1);
    endfunction

    // Signed accumulator must reach +/-filt_n.
    function automatic int acc_width(input int filt_n);
        return $clog2(filt_n + 1) + 1;
    endfunction

    function automatic int lock_width(input int lock_n);
        return $clog2(lock_n + 1);
    endfunction

    localparam int CNT_W_DEF  = cnt_width(DIV_N_DEF);
    localparam int ACC_W_DEF  = acc_width(FILT_N_DEF);
    localparam int LOCK_W_DEF = lock_width(LOCK_N_DEF);

    // One-slot merge: latch into an empty slot, drop duplicates, opposite kinds cancel.
    function automatic corr_t corr_merge(input corr_t slot, input corr_t req);
        corr_t res;
        res = slot;
        case (req)
            CORR_ADV, CORR_RET: begin
                if (slot == CORR_NONE) begin
                    res = req;
                end else if (slot == req) begin
                    res = slot;
                end else begin
                    res = CORR_NONE;
                end
            end
            default: res = slot;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bitsync_ctrl_div_rw_filter.sv
// Random-walk filter: integrates lead/lag pulses and emits a registered one-cycle
// advance/retard request whenever the accumulator reaches the threshold.
module rw_filter
    import qpsk_sync_pkg::*;
#(
    parameter int FILT_N = FILT_N_DEF
) (
    input  logic clk32,
    input  logic rst,
    input  logic i_pd_bef,
    input  logic i_pd_aft,
    output logic o_req_adv,
    output logic o_req_ret
);

    localparam int ACC_W = acc_width(FILT_N);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(FILT_N);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-FILT_N);
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_step;
    logic signed [ACC_W-1:0] w_acc_next;
    logic                    w_hit_ret;
    logic                    w_hit_adv;
    logic                    r_req_adv;
    logic                    r_req_ret;

    // Step the walk; a threshold hit clears the accumulator in the same cycle.
    always_comb begin
        w_acc_step = r_acc;
        w_acc_next = r_acc;
        if (i_pd_bef && !i_pd_aft) begin
            w_acc_step = r_acc + ACC_ONE;
        end else if (!i_pd_bef && i_pd_aft) begin
            w_acc_step = r_acc - ACC_ONE;
        end else begin
            w_acc_step = r_acc;
        end
        w_hit_ret = (w_acc_step == ACC_MAX);
        w_hit_adv = (w_acc_step == ACC_MIN);
        if (w_hit_ret || w_hit_adv) begin
            w_acc_next = '0;
        end else begin
            w_acc_next = w_acc_step;
        end
    end

    // Accumulator and request registers.
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_req_adv <= 1'b0;
            r_req_ret <= 1'b0;
        end else begin
            r_acc     <= w_acc_next;
            r_req_adv <= w_hit_adv;
            r_req_ret <= w_hit_ret;
        end
    end

    assign o_req_adv = r_req_adv;
    assign o_req_ret = r_req_ret;

endmodule

// File: rtl/bitsync_ctrl_div.sv
// DPLL control/divide stage: filtered phase corrections stretch or shorten the
// symbol period by one clk32 cycle; decodes the I/Q sync clocks, strobe and lock.
module bitsync_ctrl_div
    import qpsk_sync_pkg::*;
#(
    parameter int DIV_N  = DIV_N_DEF,
    parameter int FILT_N = FILT_N_DEF,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic clk32,
    input  logic rst,
    input  logic pd_bef,
    input  logic pd_aft,
    output logic clk_i,
    output logic clk_q,
    output logic sym_stb,
    output logic locked
);

    localparam int CNT_W  = cnt_width(DIV_N);
    localparam int LOCK_W = lock_width(LOCK_N);

    localparam logic [CNT_W-1:0]  CNT_NOM  = CNT_W'(DIV_N - 1);
    localparam logic [CNT_W-1:0]  CNT_RET  = CNT_W'(DIV_N);
    localparam logic [CNT_W-1:0]  CNT_ADV  = CNT_W'(DIV_N - 2);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIV_N / 2);
    localparam logic [CNT_W-1:0]  CNT_QTR  = CNT_W'(DIV_N / 4);
    localparam logic [CNT_W-1:0]  CNT_Q3   = CNT_W'((3 * DIV_N) / 4);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_N);
    localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);

    logic              w_req_adv;
    logic              w_req_ret;
    corr_t             w_req;
    corr_t             r_pending;
    corr_t             w_pending_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_wrap_pt;
    logic              w_wrap;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [LOCK_W-1:0] w_lock_next;
    logic              r_clk_i;
    logic              r_clk_q;
    logic              r_sym_stb;
    logic              r_locked;

    rw_filter #(
        .FILT_N (FILT_N)
    ) u_rw_filter (
        .clk32     (clk32),
        .rst       (rst),
        .i_pd_bef  (pd_bef),
        .i_pd_aft  (pd_aft),
        .o_req_adv (w_req_adv),
        .o_req_ret (w_req_ret)
    );

    // Wrap point follows the slot; on the wrap cycle the slot is replaced by any
    // fresh request so it lands in the following period.
    always_comb begin
        w_req          = CORR_NONE;
        w_wrap_pt      = CNT_NOM;
        w_cnt_next     = r_cnt;
        w_pending_next = r_pending;
        w_lock_next    = r_lock_cnt;
        if (w_req_ret && !w_req_adv) begin
            w_req = CORR_RET;
        end else if (w_req_adv && !w_req_ret) begin
            w_req = CORR_ADV;
        end else begin
            w_req = CORR_NONE;
        end
        case (r_pending)
            CORR_RET: w_wrap_pt = CNT_RET;
            CORR_ADV: w_wrap_pt = CNT_ADV;
            default:  w_wrap_pt = CNT_NOM;
        endcase
        w_wrap = (r_cnt == w_wrap_pt);
        if (w_wrap) begin
            w_cnt_next     = '0;
            w_pending_next = w_req;
            if (r_pending != CORR_NONE) begin
                w_lock_next = '0;
            end else if (r_lock_cnt == LOCK_MAX) begin
                w_lock_next = r_lock_cnt;
            end else begin
                w_lock_next = r_lock_cnt + LOCK_ONE;
            end
        end else begin
            w_cnt_next     = r_cnt + CNT_ONE;
            w_pending_next = corr_merge(r_pending, w_req);
            w_lock_next    = r_lock_cnt;
        end
    end

    // Phase counter, correction slot and lock counter.
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_pending  <= CORR_NONE;
            r_lock_cnt <= '0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_pending  <= w_pending_next;
            r_lock_cnt <= w_lock_next;
        end
    end

    // Output decode, one cycle behind the counter; count DIV_N decodes low on both clocks.
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            r_clk_i   <= 1'b0;
            r_clk_q   <= 1'b0;
            r_sym_stb <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_clk_i   <= (r_cnt < CNT_HALF);
            r_clk_q   <= (r_cnt >= CNT_QTR) && (r_cnt < CNT_Q3);
            r_sym_stb <= (r_cnt == '0);
            r_locked  <= (r_lock_cnt == LOCK_MAX);
        end
    end

    assign clk_i   = r_clk_i;
    assign clk_q   = r_clk_q;
    assign sym_stb = r_sym_stb;
    assign locked  = r_locked;

endmodule

// File: tb/tb_bitsync_ctrl_div.sv
// Scoreboard bench for bitsync_ctrl_div: expected symbol periods are queued as
// pulses are driven and compared against measured sym_stb spacing.
module tb_bitsync_ctrl_div;

    localparam int DIV_N  = 32;
    localparam int FILT_N = 4;
    localparam int LOCK_N = 16;

    logic clk32 = 1'b0;
    logic rst   = 1'b1;
    logic pd_bef = 1'b0;
    logic pd_aft = 1'b0;
    logic clk_i;
    logic clk_q;
    logic sym_stb;
    logic locked;

    int total  = 0;
    int bad    = 0;
    int streak = 0;
    int exp_q[$];

    bitsync_ctrl_div #(
        .DIV_N  (DIV_N),
        .FILT_N (FILT_N),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk32   (clk32),
        .rst     (rst),
        .pd_bef  (pd_bef),
        .pd_aft  (pd_aft),
        .clk_i   (clk_i),
        .clk_q   (clk_q),
        .sym_stb (sym_stb),
        .locked  (locked)
    );

    always #5 clk32 = ~clk32;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one symbol starting at an observed sym_stb. Pulses start at offset 2:
    // n_bef pd_bef, then n_aft pd_aft, then n_both with both high; 'late' adds a
    // pd_bef pulse sampled on the wrap edge of a nominal period.
    task automatic run_sym(input int n_bef, input int n_aft, input int n_both,
                           input bit late, input int exp_per, input string tag);
        int t;
        int hi;
        int q_off;
        int per;
        int exp_p;
        int a0;
        int a1;
        int b1;
        bit done;
        exp_q.push_back(exp_per);
        a0 = 2 + n_bef;
        a1 = a0 + n_aft;
        b1 = a1 + n_both;
        hi = int'(clk_i);
        q_off = -1;
        per = -1;
        t = 0;
        done = 1'b0;
        while (!done) begin
            pd_bef = (t >= 2 && t < a0) || (t >= a1 && t < b1) || (late && t == DIV_N - 2);
            pd_aft = (t >= a0 && t < a1) || (t >= a1 && t < b1);
            @(negedge clk32);
            t++;
            if (sym_stb) begin
                per = t;
                done = 1'b1;
            end else begin
                hi += int'(clk_i);
                if (clk_q && q_off < 0) q_off = t;
                if (t >= 2 * DIV_N) begin
                    per = t;
                    done = 1'b1;
                end
            end
        end
        pd_bef = 1'b0;
        pd_aft = 1'b0;
        exp_p = exp_q.pop_front();
        check_val({tag, ".period"}, per, exp_p);
        check_val({tag, ".i_high"}, hi, DIV_N / 2);
        check_val({tag, ".q_offset"}, q_off, DIV_N / 4);
        if (exp_p != DIV_N) streak = 0;
        else if (streak < LOCK_N) streak++;
        check_val({tag, ".locked"}, int'(locked), int'(streak == LOCK_N));
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, ".clk_i"}, int'(clk_i), 0);
        check_val({tag, ".clk_q"}, int'(clk_q), 0);
        check_val({tag, ".sym_stb"}, int'(sym_stb), 0);
        check_val({tag, ".locked"}, int'(locked), 0);
    endtask

    task automatic release_reset(input string tag);
        rst = 1'b0;
        @(negedge clk32);
        check_val({tag, ".first_clk_i"}, int'(clk_i), 1);
        check_val({tag, ".first_stb"}, int'(sym_stb), 1);
        streak = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk32);
        check_reset_outs("por");
        release_reset("por");

        repeat (18) run_sym(0, 0, 0, 1'b0, 32, "free");

        run_sym(3, 0, 0, 1'b0, 32, "bef3");
        run_sym(1, 0, 0, 1'b0, 33, "bef4");
        repeat (2) run_sym(0, 0, 0, 1'b0, 32, "bef_after");

        run_sym(0, 8, 0, 1'b0, 31, "aft8");
        repeat (2) run_sym(0, 0, 0, 1'b0, 32, "aft_after");

        run_sym(0, 0, 10, 1'b0, 32, "both");
        run_sym(4, 4, 0, 1'b0, 32, "cancel");

        run_sym(3, 0, 0, 1'b0, 32, "late_a");
        run_sym(0, 0, 0, 1'b1, 32, "late_b");
        run_sym(0, 0, 0, 1'b0, 33, "late_c");

        repeat (17) run_sym(0, 0, 0, 1'b0, 32, "relock");

        // Build acc to +3 then reset mid-period; the partial walk must be lost.
        for (int t = 0; t < 12; t++) begin
            pd_bef = (t >= 2 && t < 5);
            @(negedge clk32);
        end
        pd_bef = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outs("mid_rst_now");
        repeat (3) @(negedge clk32);
        check_reset_outs("mid_rst_hold");
        release_reset("mid_rst");

        run_sym(3, 0, 0, 1'b0, 32, "post_rst3");
        run_sym(1, 0, 0, 1'b0, 33, "post_rst4");
        run_sym(0, 0, 0, 1'b0, 32, "post_rst_nom");

        check_val("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
